// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the upstream encoder and the UART transmitter.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_en;
   logic       tx_rdy;
   logic       busy;
   modport master (output tx_data, output tx_en, input tx_rdy, input busy);
   modport slave  (input tx_data, input tx_en, output tx_rdy, output busy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 serial transmitter with one-cycle tx_rdy completion pulse.
// Defining UART_TX_PARITY_EN inserts a parity bit (sense set by PARITY_ODD).
module uart_tx #(
   parameter int CLK_FREQ   = 12000000,
   parameter int BAUD       = 115200,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_tx_if.slave bus,
   output logic     tx
);
   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd4;
   logic par;
`endif
   if (DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_tx: illegal parameter combination");
   end
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic          rdy;
   logic          busy;
   assign bus.tx_rdy = rdy;
   assign bus.busy   = busy;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         tx    <= 1'b1;
         rdy   <= 1'b0;
         busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         rdy <= 1'b0;
         if (state == IDLE) begin
            cnt <= '0;
            idx <= '0;
            if (bus.tx_en) begin
               shift <= bus.tx_data;
               state <= START;
               tx    <= 1'b0;
               busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
               par   <= ^bus.tx_data ^ 1'(PARITY_ODD);
`endif
            end
         end else if (cnt != CW'(DIV - 1)) begin
            cnt <= cnt + 1'b1;
         end else begin
            // bit boundary: the only place tx may change while a frame is active
            cnt <= '0;
            case (state)
               START: begin
                  state <= DATA;
                  tx    <= shift[0];
               end
               DATA: begin
                  if (idx == 3'd7) begin
                     idx <= '0;
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= par;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     idx   <= idx + 3'd1;
                     shift <= {1'b0, shift[7:1]};
                     tx    <= shift[1];
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
`endif
               STOP: begin
                  if (idx == 3'(STOP_BITS - 1)) begin
                     idx   <= '0;
                     state <= IDLE;
                     busy  <= 1'b0;
                     rdy   <= 1'b1;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at DIV=4.
// Instance 0: STOP_BITS=1 even parity, 1: STOP_BITS=2, 2: odd parity.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
   localparam int PE = 1;
`else
   localparam int PE = 0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic [7:0] data = 8'h00;
   int sel = 0;
   int vectors = 0;
   int errors = 0;
   logic tx0, tx1, tx2, tx_o, busy_o, rdy_o;
   uart_tx_if if0 ();
   uart_tx_if if1 ();
   uart_tx_if if2 ();
   assign if0.tx_data = data;
   assign if1.tx_data = data;
   assign if2.tx_data = data;
   assign if0.tx_en = en && sel == 0;
   assign if1.tx_en = en && sel == 1;
   assign if2.tx_en = en && sel == 2;
   uart_tx #(.CLK_FREQ(12000000), .BAUD(3000000), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .tx(tx0));
   uart_tx #(.CLK_FREQ(12000000), .BAUD(3000000), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .tx(tx1));
   uart_tx #(.CLK_FREQ(12000000), .BAUD(3000000), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .tx(tx2));
   always #5 clk = ~clk;
   always_comb begin
      tx_o   = sel == 0 ? tx0 : sel == 1 ? tx1 : tx2;
      busy_o = sel == 0 ? if0.busy : sel == 1 ? if1.busy : if2.busy;
      rdy_o  = sel == 0 ? if0.tx_rdy : sel == 1 ? if1.tx_rdy : if2.tx_rdy;
   end
   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic start_frame(input logic [7:0] d);
      en = 1'b1;
      data = d;
      @(negedge clk);
      en = 1'b0;
      data = ~d;
   endtask
   // Walks the whole frame one cycle at a time; returns in the tx_rdy cycle.
   task automatic expect_frame(input logic [7:0] d, input int nstop, input logic pbit, input int inj);
      int nb;
      logic exp_tx;
      nb = 9 + PE + nstop;
      for (int b = 0; b < nb; b++) begin
         exp_tx = b == 0 ? 1'b0 : b <= 8 ? d[b-1] : (PE == 1 && b == 9) ? pbit : 1'b1;
         for (int j = 0; j < 4; j++) begin
            vectors++;
            if (tx_o !== exp_tx || busy_o !== 1'b1 || rdy_o !== 1'b0) begin
               errors++;
               $display("FAIL frame %02h bit %0d cyc %0d: tx=%b busy=%b rdy=%b, want tx=%b busy=1 rdy=0", d, b, j, tx_o, busy_o, rdy_o, exp_tx);
            end
            if (b * 4 + j == inj) begin
               en = 1'b1;
               data = 8'hFF;
            end else if (b * 4 + j == inj + 1) begin
               en = 1'b0;
            end
            @(negedge clk);
         end
      end
      vectors++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL frame %02h end: tx=%b busy=%b rdy=%b, want tx=1 busy=0 rdy=1", d, tx_o, busy_o, rdy_o);
      end
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (tx0 !== 1'b1 || if0.busy !== 1'b0 || if0.tx_rdy !== 1'b0) begin
         errors++;
         $display("FAIL reset: tx=%b busy=%b rdy=%b, want 1/0/0", tx0, if0.busy, if0.tx_rdy);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (tx0 !== 1'b1 || if0.busy !== 1'b0 || if0.tx_rdy !== 1'b0) begin
         errors++;
         $display("FAIL idle after reset: tx=%b busy=%b rdy=%b, want 1/0/0", tx0, if0.busy, if0.tx_rdy);
      end
   endtask
   task automatic test_single;
      sel = 0;
      start_frame(8'h41);
      expect_frame(8'h41, 1, ^8'h41, -10);
      @(negedge clk);
      vectors++;
      if (rdy_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL single rdy width: rdy=%b tx=%b busy=%b, want 0/1/0", rdy_o, tx_o, busy_o);
      end
   endtask
   task automatic test_back_to_back;
      sel = 0;
      start_frame(8'h41);
      expect_frame(8'h41, 1, ^8'h41, -10);
      start_frame(8'h35);
      expect_frame(8'h35, 1, ^8'h35, -10);
      @(negedge clk);
      vectors++;
      if (rdy_o !== 1'b0 || tx_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b tail: rdy=%b tx=%b, want 0/1", rdy_o, tx_o);
      end
   endtask
   task automatic test_busy_ignore;
      int pulses;
      sel = 0;
      start_frame(8'h00);
      expect_frame(8'h00, 1, 1'b0, 12);
      pulses = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         pulses += int'(rdy_o);
         vectors++;
         if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ignore idle cyc %0d: tx=%b busy=%b, want 1/0", c, tx_o, busy_o);
         end
      end
      vectors++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL ignore extra rdy: got %0d pulses, want 0", pulses);
      end
   endtask
   task automatic test_abort;
      sel = 0;
      start_frame(8'h00);
      repeat (18) @(negedge clk);
      vectors++;
      if (tx_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL abort pre: tx=%b busy=%b, want 0/1", tx_o, busy_o);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vectors++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort reset: tx=%b busy=%b rdy=%b, want 1/0/0", tx_o, busy_o, rdy_o);
      end
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         vectors++;
         if (rdy_o !== 1'b0 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL abort idle cyc %0d: rdy=%b tx=%b, want 0/1", c, rdy_o, tx_o);
         end
      end
      start_frame(8'hA5);
      expect_frame(8'hA5, 1, ^8'hA5, -10);
      @(negedge clk);
   endtask
   task automatic test_two_stop;
      sel = 1;
      start_frame(8'h0F);
      expect_frame(8'h0F, 2, ^8'h0F, -10);
      @(negedge clk);
      vectors++;
      if (rdy_o !== 1'b0 || tx_o !== 1'b1) begin
         errors++;
         $display("FAIL two stop tail: rdy=%b tx=%b, want 0/1", rdy_o, tx_o);
      end
      sel = 0;
   endtask
   task automatic test_parity;
      sel = 0;
      start_frame(8'h07);
      expect_frame(8'h07, 1, 1'b1, -10);
      @(negedge clk);
      sel = 2;
      start_frame(8'h03);
      expect_frame(8'h03, 1, 1'b1, -10);
      @(negedge clk);
      sel = 0;
   endtask
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_busy_ignore();
      test_abort();
      test_two_stop();
      if (PE == 1) test_parity();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
